instruction_fetch_buffer: RTL and testbench

INSTRUCTION_FETCH_BUFFER -- requirements
Module: instruction_fetch_buffer

---
 rtl/instruction_fetch_buffer_if.sv | 33 +++
 rtl/instruction_fetch_buffer.sv | 120 ++++++++++++
 tb/tb_instruction_fetch_buffer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_buffer_if.sv
// Fetch-side bus of the instruction fetch buffer: request channel, instruction
// output channel and the single-outstanding memory read port.
interface instruction_fetch_buffer_if #(
    parameter int MEM_WIDTH = 32,
    parameter int MEM_SIZE  = 256
);
    localparam int AW = $clog2(MEM_SIZE);

    logic [31:0]          Address;
    logic                 req_valid;
    logic                 req_ready;
    logic                 flush;
    logic [MEM_WIDTH-1:0] Instruction;
    logic                 instr_fault;
    logic                 instr_valid;
    logic                 instr_ready;
    logic [AW-1:0]        mem_addr;
    logic                 mem_read_en;
    logic                 mem_read_valid;
    logic [MEM_WIDTH-1:0] mem_read_val;

    // master: the fetch requester / consumer / memory environment
    modport master (
        output Address, req_valid, flush, instr_ready, mem_read_valid, mem_read_val,
        input  req_ready, Instruction, instr_fault, instr_valid, mem_addr, mem_read_en
    );

    // slave: the fetch buffer itself
    modport slave (
        input  Address, req_valid, flush, instr_ready, mem_read_valid, mem_read_val,
        output req_ready, Instruction, instr_fault, instr_valid, mem_addr, mem_read_en
    );
endinterface

// File: rtl/instruction_fetch_buffer.sv
// Instruction fetch buffer: validates fetch addresses, issues one memory read at a
// time and queues returned (or faulted) instructions in a small FIFO.
module instruction_fetch_buffer #(
    parameter int MEM_WIDTH = 32,
    parameter int MEM_SIZE  = 256,
    parameter int DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    instruction_fetch_buffer_if.slave bus
);
    localparam int AW = $clog2(MEM_SIZE);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL  = CW'(DEPTH);
    localparam logic [29:0]   WORDS = 30'(MEM_SIZE);

    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

    typedef struct packed {
        logic [MEM_WIDTH-1:0] instr;
        logic                 fault;
    } entry_t;

    state_t          state;
    entry_t          fifo_q [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [AW-1:0]   mem_addr_q;
    logic            mem_read_en_q;
    logic            req_fault, accept, push, pop;
    entry_t          push_ent;

    assign req_fault     = (bus.Address[1:0] != 2'b00) || (bus.Address[31:2] >= WORDS);
    assign bus.req_ready = (state == IDLE) && (count < FULL) && !bus.flush;
    assign accept        = bus.req_valid && bus.req_ready;

    assign bus.instr_valid = (count != '0);
    assign pop             = bus.instr_valid && bus.instr_ready;
    // Storage is not reset, so the head is masked while the buffer is empty.
    assign bus.Instruction = bus.instr_valid ? fifo_q[rd_ptr].instr : '0;
    assign bus.instr_fault = bus.instr_valid && fifo_q[rd_ptr].fault;

    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_read_en = mem_read_en_q;

    // A faulting request and a memory return can never coincide: accept needs IDLE.
    always_comb begin
        push     = 1'b0;
        push_ent = '0;
        if (accept && req_fault) begin
            push           = 1'b1;
            push_ent.fault = 1'b1;
        end else if (state == WAIT && bus.mem_read_valid && !bus.flush) begin
            push           = 1'b1;
            push_ent.instr = bus.mem_read_val;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr] <= push_ent;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // WAIT owns a live read; DRAIN waits out a read whose data was flushed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            mem_read_en_q <= 1'b0;
            mem_addr_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && !req_fault) begin
                        mem_addr_q    <= bus.Address[AW+1:2];
                        mem_read_en_q <= 1'b1;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_read_valid) begin
                        mem_read_en_q <= 1'b0;
                        state         <= IDLE;
                    end else if (bus.flush) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus.mem_read_valid) begin
                        mem_read_en_q <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state         <= IDLE;
                    mem_read_en_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_fetch_buffer.sv
// Randomized scoreboard bench for instruction_fetch_buffer; expected buffer contents
// come from a queue-level model of the fetch rules and a local memory image.
module tb_instruction_fetch_buffer;
    localparam int MEM_WIDTH = 32;
    localparam int MEM_SIZE  = 256;
    localparam int DEPTH     = 4;
    localparam int NCYC      = 3000;

    typedef struct {
        logic [31:0] instr;
        logic        fault;
    } ent_t;

    logic clk;
    logic reset_n;

    instruction_fetch_buffer_if #(.MEM_WIDTH(MEM_WIDTH), .MEM_SIZE(MEM_SIZE)) bus();

    instruction_fetch_buffer #(
        .MEM_WIDTH(MEM_WIDTH),
        .MEM_SIZE (MEM_SIZE),
        .DEPTH    (DEPTH)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem_model [MEM_SIZE];
    ent_t        sb [$];
    int          pend;          // 0: no read, 1: live read, 2: read whose data is dropped
    logic [7:0]  paddr;
    bit          exp_rdy;
    bit          mon_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT outputs against model state between edges.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
                chk("instr_valid", 32'(bus.instr_valid), 32'(sb.size() != 0));
                chk("mem_read_en", 32'(bus.mem_read_en), 32'(pend != 0));
                if (pend != 0) chk("mem_addr", 32'(bus.mem_addr), 32'(paddr));
                if (sb.size() != 0) begin
                    chk("Instruction", bus.Instruction, sb[0].instr);
                    chk("instr_fault", 32'(bus.instr_fault), 32'(sb[0].fault));
                    if (bus.instr_ready) void'(sb.pop_front());
                end
                if (sb.size() > DEPTH) begin
                    failures++;
                    $display("FAIL model_overflow size=%0d limit=%0d", sb.size(), DEPTH);
                end
            end
        end
    end

    function automatic logic [31:0] gen_addr();
        int r;
        r = $urandom_range(0, 99);
        if (r < 60) return 32'($urandom_range(0, MEM_SIZE - 1)) << 2;
        if (r < 70) return (32'($urandom_range(0, MEM_SIZE - 1)) << 2) | 32'($urandom_range(1, 3));
        if (r < 75) return 32'h0000_03FC;
        if (r < 80) return 32'h0000_0400;
        if (r < 85) return 32'h0000_0402;
        return 32'h0000_0400 + ($urandom & 32'h0FFF_FFFF);
    endfunction

    // Stimulus: drives one cycle of inputs at posedge+1 and predicts that edge's effects.
    initial begin
        bit          d_flush, d_push, force_mrv, did_rst;
        ent_t        d_ent;
        int          d_pend, rdy_pct, req_pct;
        logic [7:0]  d_paddr;
        bit          f, rv, ir, mrv, flt;
        logic [31:0] a;

        for (int k = 0; k < MEM_SIZE; k++) mem_model[k] = $urandom;
        mon_en = 0; pend = 0; paddr = '0; exp_rdy = 1;
        d_flush = 0; d_push = 0; d_pend = 0; d_paddr = '0; d_ent = '{32'h0, 1'b0};
        force_mrv = 0; did_rst = 0;
        reset_n = 1'b0;
        bus.Address = '0; bus.req_valid = 0; bus.flush = 0; bus.instr_ready = 0;
        bus.mem_read_valid = 0; bus.mem_read_val = '0;

        #3;
        chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_mem_read_en", 32'(bus.mem_read_en), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_Instruction", bus.Instruction, 32'd0);
        chk("rst_instr_fault", 32'(bus.instr_fault), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        for (int i = 0; i < NCYC; i++) begin
            if (d_flush) sb.delete();
            if (d_push)  sb.push_back(d_ent);
            pend  = d_pend;
            paddr = d_paddr;

            // Asynchronous reset while a read is outstanding.
            if (!did_rst && i >= 1500 && (pend == 1 || i >= 2500)) begin
                did_rst = 1; mon_en = 0;
                bus.req_valid = 0; bus.flush = 0;
                #2 reset_n = 1'b0;
                bus.mem_read_valid = 1'b1;
                #1;
                chk("async_rst_mem_read_en", 32'(bus.mem_read_en), 32'd0);
                chk("async_rst_instr_valid", 32'(bus.instr_valid), 32'd0);
                chk("async_rst_mem_addr", 32'(bus.mem_addr), 32'd0);
                chk("async_rst_Instruction", bus.Instruction, 32'd0);
                sb.delete(); pend = 0; paddr = '0;
                repeat (2) @(posedge clk);
                #1 reset_n = 1'b1;
                force_mrv = 1;
            end

            rdy_pct = ((i / 200) % 3 == 0) ? 80 : ((i / 200) % 3 == 1) ? 10 : 50;
            req_pct = ((i / 300) % 2 == 0) ? 70 : 95;
            f   = ($urandom_range(0, 99) < 4);
            rv  = ($urandom_range(0, 99) < req_pct);
            ir  = ($urandom_range(0, 99) < rdy_pct);
            mrv = force_mrv ? 1'b1 : (pend != 0) ? ($urandom_range(0, 99) < 40)
                                                  : ($urandom_range(0, 99) < 10);
            force_mrv = 0;
            a   = gen_addr();
            flt = (a[1:0] != 2'b00) || (a[31:2] >= 30'(MEM_SIZE));

            bus.Address        = a;
            bus.req_valid      = rv;
            bus.flush          = f;
            bus.instr_ready    = ir;
            bus.mem_read_valid = mrv;
            bus.mem_read_val   = (pend != 0) ? mem_model[bus.mem_addr] : $urandom;
            exp_rdy = (pend == 0) && (sb.size() < DEPTH) && !f;
            mon_en  = 1;

            d_flush = f; d_push = 0; d_pend = pend; d_paddr = paddr;
            if (f) begin
                if (pend != 0 && mrv) d_pend = 0;
                else if (pend == 1)   d_pend = 2;
            end else if (pend == 0) begin
                if (rv && exp_rdy) begin
                    if (flt) begin
                        d_push = 1; d_ent = '{32'h0, 1'b1};
                    end else begin
                        d_pend = 1; d_paddr = a[9:2];
                    end
                end
            end else if (mrv) begin
                if (pend == 1) begin
                    d_push = 1; d_ent = '{mem_model[paddr], 1'b0};
                end
                d_pend = 0;
            end

            @(posedge clk);
            #1;
        end

        mon_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
